// File: rtl/mult_unit_if.sv
// Request/result bundle for the iterative multiplier.
// master drives operands and start; slave returns status and HI/LO.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative unsigned shift-add multiplier feeding the HI/LO registers.
// One product bit per cycle; HI/LO only move on a completion edge.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mult_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               accept;
  logic               last;

  assign accept = bus.start && (state_q != RUN);
  assign last   = (state_q == RUN) &&
                  (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Carry of the upper-half add is kept and shifted back in.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) sum = sum + {1'b0, mcand};
    acc_step = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (accept) begin
      mcand <= bus.a;
      acc   <= {{WIDTH{1'b0}}, bus.b};
      cnt   <= '0;
    end else if (state_q == RUN) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
      if (last) {hi_q, lo_q} <= acc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: products, hold, ignored start,
// mid-op reset and back-to-back acceptance.
module tb_mult_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   npass;
  int   ntotal;

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_start(input logic [W-1:0] av,
                          input logic [W-1:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ntotal++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL reset_flags got=%b exp=00",
               {bus.busy, bus.done});
    else npass++;
    ntotal++;
    if ({bus.hi, bus.lo} !== 64'h0)
      $display("FAIL reset_hilo got=%h exp=0",
               {bus.hi, bus.lo});
    else npass++;
  endtask

  task automatic test_basic;
    int cyc;
    do_start(32'd3, 32'd5);
    ntotal++;
    if (bus.busy !== 1'b1)
      $display("FAIL basic_busy_rise got=%b exp=1", bus.busy);
    else npass++;
    wait_done(cyc);
    ntotal++;
    if (cyc !== 32)
      $display("FAIL basic_busy_len got=%0d exp=32", cyc);
    else npass++;
    ntotal++;
    if (bus.done !== 1'b1)
      $display("FAIL basic_done got=%b exp=1", bus.done);
    else npass++;
    ntotal++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_0000_000F)
      $display("FAIL basic_prod got=%h exp=%h",
               {bus.hi, bus.lo}, 64'hF);
    else npass++;
    @(negedge clk);
    ntotal++;
    if (bus.done !== 1'b0)
      $display("FAIL basic_done_pulse got=%b exp=0", bus.done);
    else npass++;
  endtask

  task automatic test_max;
    int cyc;
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    ntotal++;
    if (bus.done !== 1'b1)
      $display("FAIL max_done got=%b exp=1", bus.done);
    else npass++;
    ntotal++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL max_prod got=%h exp=%h",
               {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    else npass++;
  endtask

  task automatic test_zero_hold;
    int cyc;
    int bad;
    do_start(32'h1234_5678, 32'h0001_0000);
    wait_done(cyc);
    ntotal++;
    if ({bus.hi, bus.lo} !== 64'h0000_1234_5678_0000)
      $display("FAIL shift_prod got=%h exp=%h",
               {bus.hi, bus.lo}, 64'h0000_1234_5678_0000);
    else npass++;
    do_start(32'h0, 32'hDEAD_BEEF);
    bad = 0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      if ({bus.hi, bus.lo} !== 64'h0000_1234_5678_0000)
        bad++;
      @(negedge clk);
      cyc++;
    end
    ntotal++;
    if (bad !== 0)
      $display("FAIL hold_during_busy bad=%0d exp=0", bad);
    else npass++;
    ntotal++;
    if (bus.done !== 1'b1)
      $display("FAIL zero_done got=%b exp=1", bus.done);
    else npass++;
    ntotal++;
    if ({bus.hi, bus.lo} !== 64'h0)
      $display("FAIL zero_prod got=%h exp=0", {bus.hi, bus.lo});
    else npass++;
  endtask

  task automatic test_ignored_start;
    int r;
    int extra;
    do_start(32'd2, 32'd9);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd7;
    bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(r);
    ntotal++;
    if (10 + r !== 32)
      $display("FAIL ign_busy_len got=%0d exp=32", 10 + r);
    else npass++;
    ntotal++;
    if ({bus.hi, bus.lo} !== 64'd18)
      $display("FAIL ign_prod got=%h exp=%h",
               {bus.hi, bus.lo}, 64'd18);
    else npass++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    ntotal++;
    if (extra !== 0)
      $display("FAIL ign_extra_done got=%0d exp=0", extra);
    else npass++;
  endtask

  task automatic test_mid_reset;
    int seen;
    do_start(32'hFFFF, 32'hFFFF);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ntotal++;
    if (bus.busy !== 1'b0)
      $display("FAIL mid_rst_busy got=%b exp=0", bus.busy);
    else npass++;
    ntotal++;
    if ({bus.hi, bus.lo} !== 64'h0)
      $display("FAIL mid_rst_hilo got=%h exp=0",
               {bus.hi, bus.lo});
    else npass++;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    ntotal++;
    if (seen !== 0)
      $display("FAIL mid_rst_done got=%0d exp=0", seen);
    else npass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    int bad;
    do_start(32'd3, 32'd5);
    wait_done(cyc);
    ntotal++;
    if (bus.done !== 1'b1)
      $display("FAIL b2b_first_done got=%b exp=1", bus.done);
    else npass++;
    bus.start = 1'b1;
    bus.a = 32'd4;
    bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    ntotal++;
    if ({bus.busy, bus.done} !== 2'b10)
      $display("FAIL b2b_busy_rise got=%b exp=10",
               {bus.busy, bus.done});
    else npass++;
    bad = 0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      if ({bus.hi, bus.lo} !== 64'hF) bad++;
      @(negedge clk);
      cyc++;
    end
    ntotal++;
    if (bad !== 0)
      $display("FAIL b2b_hold bad=%0d exp=0", bad);
    else npass++;
    ntotal++;
    if (cyc !== 32)
      $display("FAIL b2b_latency got=%0d exp=32", cyc);
    else npass++;
    ntotal++;
    if (bus.done !== 1'b1 || {bus.hi, bus.lo} !== 64'd24)
      $display("FAIL b2b_prod done=%b got=%h exp=%h",
               bus.done, {bus.hi, bus.lo}, 64'd24);
    else npass++;
  endtask

  initial begin
    npass = 0;
    ntotal = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero_hold();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative unsigned shift-add multiplier that produces the HI/LO product registers for `multu`. It sits directly upstream of the register-file write-back select mux. That mux chooses among ALU result, data-memory read, HI and LO for `mfhi`/`mflo`. HI/LO change only when a multiply completes, so the write-back path sees stable values at all other times.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a multiply; sampled on the rising edge; accepted only when `busy`=0.
- `a`  input  WIDTH  multiplicand; unsigned; sampled on the accepting edge only.
- `b`  input  WIDTH  multiplier; unsigned; sampled on the accepting edge only.
- `busy`  output  1  high while an accepted multiply is iterating.
- `done`  output  1  one-cycle pulse; HI/LO hold the new product during this cycle.
- `hi`  output  WIDTH  upper half of the last completed product.
- `lo`  output  WIDTH  lower half of the last completed product.

## Operation
- States:
  - IDLE: waiting, `busy`=0, `done`=0.
  - RUN: iterating, `busy`=1.
  - DONE: one cycle, `done`=1, `busy`=0.
- Transitions:
  - IDLE -> RUN on `start`.
  - RUN -> DONE after exactly `WIDTH` iterations.
  - DONE -> RUN on `start`, else DONE -> IDLE.
- Accept:
  - Latch `a` into the multiplicand register.
  - Load the `2*WIDTH` product accumulator with {`WIDTH`'b0, `b`}.
  - Clear the iteration counter. Counter width is clog2(`WIDTH`)+1.
- Each RUN cycle:
  - If accumulator bit 0 is 1, add the multiplicand to the accumulator upper half using a `WIDTH`+1-bit sum so the carry is kept.
  - Shift {carry, upper, lower} right by 1.
  - Increment the counter.
- Completion:
  - The edge performing iteration `WIDTH` writes the final accumulator to {`hi`,`lo`} and enters DONE.
  - The product is exact; no overflow is possible since `2*WIDTH` bits hold any `WIDTH`x`WIDTH` product.
- `start` while `busy`=1 is ignored, with no effect on the operation in flight or on `a`/`b` capture.
- `start` during DONE is accepted (back-to-back). The completed `hi`/`lo` remain held until the next completion.
- `hi`/`lo` never show partial products. They change only on a completion edge or on reset.
- Reset:
  - `rst`=1 at any edge forces IDLE and `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - The accumulator and counter are cleared.
  - An in-flight multiply is abandoned with no completion.
  - `rst` has priority over `start` on the same edge.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - State IDLE.
- Edge numbering: `start` is accepted at edge E0.
- `busy`:
  - Goes high after E0.
  - Is high for exactly `WIDTH` cycles.
  - Drops after edge E`WIDTH`.
- Results: `hi`/`lo` update at E`WIDTH`, and `done` is high in the single cycle following E`WIDTH`.
- Latency: `WIDTH` cycles from accept to result (32 cycles at default).
- Back-to-back throughput: one product every `WIDTH`+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic product: reset, then `start` with a=3, b=5.
  - `busy` is high for 32 cycles.
  - `done` pulses once.
  - After the pulse, `hi`=0x00000000 and `lo`=0x0000000F.
- Max operands: a=0xFFFFFFFF, b=0xFFFFFFFF.
  - `hi`=0xFFFFFFFE and `lo`=0x00000001 (carry-out path).
- Zero and held outputs:
  - First run a=0x12345678, b=0x00010000, giving `hi`=0x00001234 and `lo`=0x56780000.
  - Then run a=0, b=0xDEADBEEF.
  - `hi`/`lo` hold 0x00001234/0x56780000 throughout the second run's `busy` window.
  - They become 0/0 at the second run's `done`.
- Ignored start: pulse `start` with a=7, b=7 at cycle 10 of a run of a=2, b=9.
  - Result is `hi`=0, `lo`=18.
  - No extra `done` pulse.
  - `busy` falls on schedule.
- Mid-op reset: assert `rst` at cycle 16 of a=0xFFFF, b=0xFFFF.
  - Next cycle: `busy`=0, `hi`=0, `lo`=0.
  - No `done` pulse ever follows.
- Back-to-back: assert `start` (a=4, b=6) during a `done` cycle of an earlier run.
  - `busy` rises immediately after that edge.
  - The first result stays visible until the second `done`.
  - The second `done` comes 32 cycles later with `lo`=24.
